// File: rtl/vga_timing_pkg.sv
// Shared constants and elaboration helpers for the VGA raster timing generator.
// Defaults describe the standard 640x480 @ 60 Hz mode.
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Sync window is [start, stop) in axis units; total is the full period.
    typedef struct packed {
        logic [31:0] start;
        logic [31:0] stop;
        logic [31:0] total;
    } sync_win_t;

    function automatic sync_win_t sync_window(input int visible, input int front,
                                              input int sync_w, input int back);
        sync_win_t win;
        win.start = 32'(visible + front);
        win.stop  = 32'(visible + front + sync_w);
        win.total = 32'(visible + front + sync_w + back);
        return win;
    endfunction

    function automatic int counter_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with sync and visible-area flags
// registered from the next count so they change on the same edge as the count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = DEF_H_VISIBLE,
    parameter int FRONT   = DEF_H_FRONT,
    parameter int SYNC    = DEF_H_SYNC,
    parameter int BACK    = DEF_H_BACK,
    parameter bit POL     = 1'b0,
    parameter int W       = 10
) (
    input  logic         i_Clk,
    input  logic         i_Rst_L,
    input  logic         i_Clear,
    input  logic         i_Step,
    output logic [W-1:0] o_Count,
    output logic         o_Sync,
    output logic         o_Visible,
    output logic         o_Last
);

    localparam sync_win_t      WIN    = sync_window(VISIBLE, FRONT, SYNC, BACK);
    localparam logic [W-1:0]   LAST_C = W'(WIN.total - 32'd1);
    localparam logic [31:0]    VIS_C  = 32'(VISIBLE);

    logic [W-1:0] count_next;
    logic         sync_next;
    logic         vis_next;

    assign o_Last = (o_Count == LAST_C);

    always_comb begin
        count_next = o_Count;
        if (i_Clear) begin
            count_next = '0;
        end else if (i_Step) begin
            count_next = o_Last ? '0 : o_Count + W'(1);
        end
        sync_next = (32'(count_next) >= WIN.start) && (32'(count_next) < WIN.stop);
        vis_next  = 32'(count_next) < VIS_C;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Count   <= '0;
            o_Sync    <= ~POL;
            o_Visible <= 1'b0;
        end else begin
            o_Count   <= count_next;
            o_Sync    <= (!i_Clear && sync_next) ? POL : ~POL;
            o_Visible <= !i_Clear && vis_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-clock prescaler, H/V axis counters,
// run/stop control, line/frame strobes and a completed-frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CLK_DIV   = 1,
    parameter int CNT_W     = 10,
    parameter int FRAME_W   = 8
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Enable,
    output logic               o_Pix_Ce,
    output logic               o_VGA_HSync,
    output logic               o_VGA_VSync,
    output logic               o_Active,
    output logic [CNT_W-1:0]   o_H_Counter,
    output logic [CNT_W-1:0]   o_V_Counter,
    output logic               o_Line_Start,
    output logic               o_Frame_Start,
    output logic [FRAME_W-1:0] o_Frame_Count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int PRE_W   = counter_width(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (counter_width(H_TOTAL) > CNT_W || counter_width(V_TOTAL) > CNT_W) begin : g_bad_width
        $error("vga_timing_gen: CNT_W too small for the configured totals");
    end
    if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
        $error("vga_timing_gen: sync widths must be non-zero");
    end

    logic             run_q;
    logic [PRE_W-1:0] prescaler;
    logic             h_last;
    logic             v_last;
    logic             h_vis;
    logic             v_vis;
    logic             line_q;
    logic             frame_q;

    // run_q marks that the previous edge was enabled; its absence means "start at origin".
    assign o_Pix_Ce      = run_q && (prescaler == PRE_LAST);
    assign o_Active      = h_vis && v_vis;
    assign o_Line_Start  = line_q;
    assign o_Frame_Start = frame_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            run_q     <= 1'b0;
            prescaler <= '0;
        end else begin
            run_q <= i_Enable;
            if (!i_Enable || !run_q || o_Pix_Ce) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + PRE_W'(1);
            end
        end
    end

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .POL     (HSYNC_POL),
        .W       (CNT_W)
    ) u_h_axis (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Clear   (!i_Enable),
        .i_Step    (o_Pix_Ce),
        .o_Count   (o_H_Counter),
        .o_Sync    (o_VGA_HSync),
        .o_Visible (h_vis),
        .o_Last    (h_last)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .POL     (VSYNC_POL),
        .W       (CNT_W)
    ) u_v_axis (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Clear   (!i_Enable),
        .i_Step    (o_Pix_Ce && h_last),
        .o_Count   (o_V_Counter),
        .o_Sync    (o_VGA_VSync),
        .o_Visible (v_vis),
        .o_Last    (v_last)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            line_q        <= 1'b0;
            frame_q       <= 1'b0;
            o_Frame_Count <= '0;
        end else begin
            line_q  <= i_Enable && (!run_q || (o_Pix_Ce && h_last));
            frame_q <= i_Enable && (!run_q || (o_Pix_Ce && h_last && v_last));
            if (i_Enable && o_Pix_Ce && h_last && v_last) begin
                o_Frame_Count <= o_Frame_Count + FRAME_W'(1);
            end
        end
    end

endmodule
